// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register with a 2-entry skid buffer. Carries a data
//   bundle and a control bundle between stages (EX/MEM, MEM/WB, ...).
//   in_ready comes from registered state (plus flush only), so a downstream
//   stall never forms a combinational path back upstream.
//
// Handshake: a beat moves across an interface on a rising clk edge where
//   valid and ready are both 1 (acc on the input side, pop on the output side).
//   The producer may not assume acceptance until it sees ready=1 in that cycle.
//   Once out_valid=1, out_data/out_ctrl are held until the beat is popped.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   flush         synchronous kill of all stored entries (bubble insert)
//   in_valid/in_ready/in_data/in_ctrl     upstream side
//   out_valid/out_ready/out_data/out_ctrl downstream side (head entry)
//   occupancy     number of held entries (0..2)
//   dbg_state     current FSM state (EMPTY=0, ONE=1, FULL=2)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned DATA_W        = 69,
  parameter int unsigned CTRL_W        = 4,
  parameter bit          ZERO_DATA_BUB = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic main_valid;
  logic skid_valid;
  logic acc;
  logic pop;

  // Entry valids are implied by the state: main is valid in ONE/FULL,
  // skid only in FULL.
  assign main_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign skid_valid = (state_q == ST_FULL);

  assign in_ready  = ~skid_valid & ~flush;
  assign out_valid = main_valid;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Control is gated so downstream never sees a stale RegWrite/MemWrite.
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};
  assign out_data  = (ZERO_DATA_BUB && !main_valid) ? '0 : main_data_q;
  assign dbg_state = state_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // in_ready is 0 during flush, so nothing is accepted; any pop in this
      // cycle completes downstream and the stage simply forgets everything.
      state_d     = ST_EMPTY;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (acc) begin
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
module tb_pipe_stage_skid;
  localparam int DW = 69;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [1:0]    dbg_state;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_BUB(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW+CW-1:0] exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic acc_ok = 1'b0;
  logic prev_rst = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries. Accepts when it holds fewer
  // than two and flush is low; flush or rst empties it.
  always begin
    @(negedge clk);
    #1;
    acc_ok = (exp_q.size() < 2) && !flush;
    #3;
    if (rst || flush) exp_q.delete();
    else if (in_valid && acc_ok) exp_q.push_back({in_data, in_ctrl});
  end

  // Monitor: checks the presented head against the model and pops on transfer.
  always begin
    logic r0;
    logic save_rdy;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_rst = 1'b1;
    end else begin
      chk("in_ready", in_ready, acc_ok);
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("occupancy", occupancy, exp_q.size());
      if (prev_rst) chk("rst_out_data", out_data, '0);
      if (exp_q.size() == 0) begin
        chk("bubble_ctrl", out_ctrl, '0);
      end else begin
        chk("out_data", out_data, exp_q[0][DW+CW-1:CW]);
        chk("out_ctrl", out_ctrl, exp_q[0][CW-1:0]);
      end
      save_rdy  = out_ready;
      r0        = in_ready;
      out_ready = ~save_rdy;
      #1;
      chk("ready_indep", in_ready, r0);
      out_ready = save_rdy;
      if (save_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_rst = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  // Holds a beat on the input until the stage takes it, bounded.
  task automatic send_beat(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
    bit taken = 0;
    for (int i = 0; i < 20 && !taken; i++) begin
      drive(1'b0, 1'b0, 1'b1, d, c, ordy);
      #1;
      taken = in_ready;
    end
    if (!taken) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: beat %0h not accepted within 20 cycles", d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [95:0] rnd;
    // 1. reset for two cycles, then idle
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(3, 1'b0);
    chk("reset_occ", occupancy, 2'd0);
    chk("reset_in_ready", in_ready, 1'b1);

    // 2. back-to-back stream
    for (int i = 1; i <= 8; i++) send_beat(DW'(i), 4'b1001, 1'b1);
    idle(3, 1'b1);

    // 3. stall fills the skid; 0xC waits at the input
    send_beat(DW'('hA), 4'b0011, 1'b0);
    send_beat(DW'('hB), 4'b0101, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, DW'('hC), 4'b0110, 1'b0);
    chk("full_in_ready", in_ready, 1'b0);
    send_beat(DW'('hC), 4'b0110, 1'b1);
    idle(4, 1'b1);

    // 4. flush while full with a beat offered
    send_beat(DW'('h11), 4'b1111, 1'b0);
    send_beat(DW'('h22), 4'b1110, 1'b0);
    drive(1'b0, 1'b1, 1'b1, DW'('h33), 4'b1011, 1'b0);
    idle(1, 1'b1);
    chk("flush_occ", occupancy, 2'd0);
    chk("flush_ctrl", out_ctrl, '0);
    idle(3, 1'b1);

    // 5. reset while full with out_ready toggling
    send_beat(DW'('h44), 4'b1000, 1'b0);
    send_beat(DW'('h55), 4'b0100, 1'b0);
    drive(1'b1, 1'b0, 1'b1, DW'('h66), 4'b0010, 1'b1);
    drive(1'b1, 1'b0, 1'b1, DW'('h66), 4'b0010, 1'b0);
    idle(1, 1'b0);
    chk("rst_full_occ", occupancy, 2'd0);
    chk("rst_full_valid", out_valid, 1'b0);
    send_beat(DW'('h5A), 4'b1001, 1'b1);
    idle(3, 1'b1);

    // 6. random traffic
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      drive(($urandom_range(0, 999) == 0), ($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 1)), rnd[DW-1:0], 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
    end
    idle(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
